// File: rtl/slt_pkg.sv
// slt_pkg: shared FSM states and sizing helper for the chunk-serial comparator
package slt_pkg;
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   function automatic int chunks(input int n, input int w);
      return n / w;
   endfunction
endpackage

// File: rtl/chunk_cmp.sv
// chunk_cmp: one-chunk compare; flip_msb turns an unsigned compare into a signed one
module chunk_cmp #(
   parameter int W = 8
) (
   input  logic [W-1:0] ca,
   input  logic [W-1:0] cb,
   input  logic         flip_msb,
   output logic         c_lt,
   output logic         c_eq
);
   logic [W-1:0] m;
   assign m    = flip_msb ? W'(1) << (W - 1) : '0;
   assign c_lt = (ca ^ m) < (cb ^ m);
   assign c_eq = ca == cb;
endmodule

// File: rtl/slt_serial.sv
// slt_serial: compares two N-bit operands W bits per cycle, MS chunk first, with early exit
module slt_serial import slt_pkg::*; #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         is_signed,
   input  logic         i_valid,
   output logic         i_ready,
   output logic         o_valid,
   input  logic         o_ready,
   output logic         lt,
   output logic         eq
);
   localparam int C  = chunks(N, W);
   localparam int CW = C > 1 ? $clog2(C) : 1;
   if (W < 1 || W > N || N % W != 0) begin : g_bad
      $error("slt_serial: N must be a positive multiple of W");
   end
   state_t        state_q, state_d;
   logic [N-1:0]  a_q, a_d, b_q, b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sgn_q, sgn_d, lt_q, lt_d, eq_q, eq_d, c_lt, c_eq;
   // the sign fix only applies to the chunk holding the operand MSBs
   chunk_cmp #(.W(W)) u_cmp (
      .ca       (a_q[N-1 -: W]),
      .cb       (b_q[N-1 -: W]),
      .flip_msb (sgn_q && cnt_q == '0),
      .c_lt     (c_lt),
      .c_eq     (c_eq)
   );
   assign i_ready = state_q == S_IDLE && !rst;
   assign o_valid = state_q == S_DONE;
   assign lt      = lt_q;
   assign eq      = eq_q;
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      cnt_d   = cnt_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      case (state_q)
         S_IDLE: if (i_valid) begin
            a_d     = a;
            b_d     = b;
            sgn_d   = is_signed;
            cnt_d   = '0;
            state_d = S_BUSY;
         end
         S_BUSY: if (!c_eq || cnt_q == CW'(C - 1)) begin
            lt_d    = !c_eq && c_lt;
            eq_d    = c_eq;
            state_d = S_DONE;
         end else begin
            a_d   = N'({a_q, W'(0)});
            b_d   = N'({b_q, W'(0)});
            cnt_d = cnt_q + 1'b1;
         end
         S_DONE: state_d = o_ready ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
      end
   end
   always_ff @(posedge clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      sgn_q <= sgn_d;
   end
endmodule

// File: tb/tb_slt_serial.sv
// tb_slt_serial: scoreboard bench for three N/W configurations run side by side
module tb_slt_serial;
   typedef struct {logic lt; logic eq; int k; int e0;} exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int checks = 0, errors = 0, done_cnt = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask
   for (genvar k = 0; k < 3; k++) begin : g_cfg
      localparam int NN = k == 2 ? 16 : 32;
      localparam int WW = k == 0 ? 8 : (k == 1 ? 1 : 16);
      logic rst = 1'b1, sgn = 1'b0, iv = 1'b0, ordy = 1'b1, rnd = 1'b0, ovp = 1'b0;
      logic ir, ov, lt, eq;
      logic [NN-1:0] a = '0, b = '0;
      exp_t q[$];
      slt_serial #(.N(NN), .W(WW)) dut (
         .clk(clk), .rst(rst), .a(a), .b(b), .is_signed(sgn), .i_valid(iv),
         .i_ready(ir), .o_valid(ov), .o_ready(ordy), .lt(lt), .eq(eq)
      );
      // cycles to result = number of leading chunks up to and including the first mismatch
      function automatic int lat(input logic [NN-1:0] x, input logic [NN-1:0] y);
         for (int i = 0; i < NN / WW; i++)
            if ((x >> (NN - (i + 1) * WW)) != (y >> (NN - (i + 1) * WW))) return i + 1;
         return NN / WW;
      endfunction
      task automatic send(input logic [NN-1:0] x, input logic [NN-1:0] y, input logic s);
         exp_t e;
         int n = 0;
         @(negedge clk);
         a = x; b = y; sgn = s; iv = 1'b1;
         while (!ir && n < 400) begin @(negedge clk); n++; end
         if (!ir) begin
            checks++; errors++;
            $display("FAIL cfg%0d handshake timeout: i_ready=0 expected 1", k);
         end else begin
            e.lt = s ? ($signed(x) < $signed(y)) : (x < y);
            e.eq = x == y;
            e.k  = lat(x, y);
            e.e0 = cyc + 1;
            q.push_back(e);
         end
         @(posedge clk); #1;
         iv = 1'b0; a = NN'($urandom); b = NN'($urandom); sgn = 1'($urandom);
      endtask
      task automatic drain();
         int n = 0;
         while (q.size() != 0 && n < 400) begin @(negedge clk); n++; end
         if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL cfg%0d drain timeout: pending=%0d expected 0", k, q.size());
         end
      endtask
      always @(posedge clk) begin
         #1;
         if (rnd) ordy = $urandom_range(0, 2) != 0;
      end
      always @(negedge clk) begin
         if (rst) ovp = 1'b0;
         else begin
            if (ov) begin
               chk($sformatf("cfg%0d i_ready_in_done", k), 32'(ir), 0);
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL cfg%0d spurious_result: o_valid=1 expected 0", k);
               end else begin
                  chk($sformatf("cfg%0d lt", k), 32'(lt), 32'(q[0].lt));
                  chk($sformatf("cfg%0d eq", k), 32'(eq), 32'(q[0].eq));
                  if (!ovp) chk($sformatf("cfg%0d latency", k), cyc - q[0].e0, q[0].k);
                  if (ordy) void'(q.pop_front());
               end
            end
            ovp = ov && !ordy;
         end
      end
      initial begin
         logic [NN-1:0] x, y;
         int n;
         repeat (2) @(negedge clk);
         chk($sformatf("cfg%0d i_ready_in_reset", k), 32'(ir), 0);
         rst = 1'b0;
         #1;
         chk($sformatf("cfg%0d reset_o_valid", k), 32'(ov), 0);
         chk($sformatf("cfg%0d reset_lt", k), 32'(lt), 0);
         chk($sformatf("cfg%0d reset_eq", k), 32'(eq), 0);
         chk($sformatf("cfg%0d reset_i_ready", k), 32'(ir), 1);
         send('0, '0, 1'b1);
         send(NN'(32'hFFFFFFFF), NN'(32'h1), 1'b1);
         send(NN'(32'hFFFFFFFF), NN'(32'h1), 1'b0);
         send(NN'(32'h7FFFFFFF), NN'(32'h80000000), 1'b1);
         send(NN'(32'h7FFFFFFF), NN'(32'h80000000), 1'b0);
         drain();
         @(posedge clk); #1;
         ordy = 1'b0;
         send(NN'(32'h12345600), NN'(32'h12345601), 1'b0);
         n = 0;
         while (!ov && n < 50) begin @(negedge clk); n++; end
         chk($sformatf("cfg%0d stall_reach_done", k), 32'(ov), 1);
         repeat (3) begin
            chk($sformatf("cfg%0d stall_hold", k), 32'(ov), 1);
            iv = 1'b1; a = '0; b = '0;
            @(negedge clk);
         end
         iv = 1'b0;
         chk($sformatf("cfg%0d stall_hold_end", k), 32'(ov), 1);
         @(posedge clk); #1;
         ordy = 1'b1;
         drain();
         send('0, '0, 1'b1);
         @(negedge clk); @(negedge clk);
         rst = 1'b1;
         q.delete();
         @(negedge clk);
         rst = 1'b0;
         #1;
         chk($sformatf("cfg%0d abort_o_valid", k), 32'(ov), 0);
         chk($sformatf("cfg%0d abort_i_ready", k), 32'(ir), 1);
         repeat (NN / WW + 4) @(negedge clk);
         rnd = 1'b1;
         repeat (1000) begin
            x = NN'($urandom);
            n = $urandom_range(0, 3);
            y = n == 0 ? x : n == 1 ? x ^ (NN'(1) << $urandom_range(0, NN - 1)) : NN'($urandom);
            send(x, y, 1'($urandom));
         end
         rnd = 1'b0;
         @(posedge clk); #2;
         ordy = 1'b1;
         drain();
         done_cnt++;
      end
   end
   initial begin
      int n = 0;
      while (done_cnt < 3 && n < 150000) begin @(negedge clk); n++; end
      if (done_cnt < 3) begin
         checks++; errors++;
         $display("FAIL global_timeout: finished configs %0d expected 3", done_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/slt_serial.md
# slt_serial

Parametrised, multi-cycle successor to the combinational set-less-than block. Compares two N-bit operands W bits per cycle, most-significant chunk first, in signed or unsigned mode, and terminates early on the first differing chunk. It sits between an operand producer and a result consumer on valid/ready handshakes, so wide compares need no N-bit-deep carry chain in one cycle.

## Interface
- N, 32, operand width; must be a multiple of W.
- W, 8, chunk width compared per cycle; 1 ≤ W ≤ N.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  N  operand A; sampled only on input handshake.
- b  in  N  operand B; sampled only on input handshake.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b.
- i_valid  in  1  producer has a/b/is_signed.
- i_ready  out  1  block can accept; high only in IDLE.
- o_valid  out  1  lt/eq hold a valid result.
- o_ready  in  1  consumer takes result.
- lt  out  1  a < b under selected mode.
- eq  out  1  a == b.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: i_ready=1. On i_valid&i_ready, load a, b into shift registers, latch is_signed, clear chunk counter, go BUSY.
- BUSY: compare the top W bits of each shift register. In chunk 0 only, if is_signed, invert the MSB of both chunks before the unsigned compare. This is the sign fix that makes 0x7FFFFFFF > 0x80000000.
  - Chunks differ: register lt = (chunk_a < chunk_b), eq=0, go DONE.
  - Chunks equal and counter == N/W-1: register lt=0, eq=1, go DONE.
  - Otherwise: shift both registers left by W, increment counter, stay BUSY.
- DONE: o_valid=1; lt/eq stable. On o_ready, go IDLE. lt/eq keep their last value in IDLE, but are don't-care while o_valid=0.
- No overlap: a new operand pair is never accepted while BUSY or DONE.
- Counter width is $clog2(N/W), minimum 1 bit. When N == W, a compare is a single BUSY cycle.

## Timing
- Reset (rst high at an edge) forces: state IDLE, o_valid=0, lt=0, eq=0, counter=0.
- i_ready = (state==IDLE) & ~rst, so it is 0 during the reset cycle.
- Reset asserted in any state, including mid-BUSY or in DONE with o_ready low, aborts the operation. No result is produced for that operation.
- Latency: the input handshake occurs at edge E0. o_valid rises at edge E0+k, where k = 1 + index of the first differing chunk (1..N/W). Equal operands take N/W cycles.
- DONE with o_ready already high: the result is consumed in its first cycle. IDLE follows at the next edge, so i_ready is high one cycle after o_valid.
- Minimum initiation interval: k+2 cycles.
- Inputs a/b/is_signed may change freely when no handshake is occurring. They may also change after the handshake without affecting the result.
- i_valid may be asserted in DONE. It is ignored until IDLE.

## Structure
- Package slt_pkg:
  - typedef enum logic [1:0] state_t {S_IDLE, S_BUSY, S_DONE}.
  - Function chunks(N,W) returning N/W.
- Sub-module chunk_cmp: combinational, parameter W. Inputs ca, cb, flip_msb; outputs c_lt, c_eq. Instantiated once.
- Top level holds the FSM, the shift registers, the counter and the result registers.
- Elaboration-time assertion that N % W == 0.

## Test plan
All cases use N=32, W=8 unless stated.
- a=0, b=0, signed: eq=1, lt=0; o_valid 4 cycles after the handshake.
- a=0xFFFFFFFF, b=1: signed gives lt=1, eq=0 with o_valid 1 cycle after the handshake; unsigned gives lt=0 with the same latency.
- a=0x7FFFFFFF, b=0x80000000 (overflow edge): signed gives lt=0; unsigned gives lt=1.
- a=0x12345600, b=0x12345601, unsigned: lt=1 after 4 cycles. Hold o_ready=0 for 3 cycles: o_valid/lt stay high and stable, i_ready stays 0, and an i_valid pulse in that window is not accepted.
- Reset mid-compare: a=0, b=0, rst pulsed 2 cycles after the handshake. Next cycle: state IDLE, o_valid=0, i_ready=1, and no stale result ever appears.
- Random: 1000 handshakes with random a/b/is_signed and random o_ready stalls, checked with === against a behavioural signed/unsigned '<' and '=='. Repeat with N=32, W=1 and with N=16, W=16.
